// File: rtl/img_ram_loader.sv
// Byte-stream loader for the image RAM write port: buffers pixels from a
// valid/ready source and writes them to consecutive addresses from a base.
module img_ram_loader #(
    parameter int unsigned                ADDR_WIDTH = 20,
    parameter int unsigned                DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0]      MAX_ADDRS  = 20'hFFFFF,
    parameter int unsigned                FIFO_DEPTH = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [ADDR_WIDTH-1:0] BASE_ADDRS,
    input  logic [ADDR_WIDTH-1:0] LENGTH,
    input  logic                  IN_VALID,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    output logic                  IN_READY,
    input  logic                  HOLD,
    output logic [ADDR_WIDTH-1:0] WRITE_ADDRS,
    output logic [DATA_WIDTH-1:0] WRT_DATA,
    output logic                  WRT_ENA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERROR,
    output logic [ADDR_WIDTH-1:0] COUNT
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0]      OCC_ZERO    = {OCC_W{1'b0}};
    localparam logic [OCC_W-1:0]      OCC_FULL    = OCC_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]      PTR_ZERO    = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]      PTR_LAST    = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO   = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO   = {DATA_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH:0]   RANGE_LIMIT = {1'b0, MAX_ADDRS} + (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? PTR_ZERO : p + PTR_W'(1);
    endfunction

    state_t                state_q,       state_d;
    logic [ADDR_WIDTH-1:0] base_q,        base_d;
    logic [ADDR_WIDTH-1:0] length_q,      length_d;
    logic [ADDR_WIDTH-1:0] accepted_q,    accepted_d;
    logic [ADDR_WIDTH-1:0] written_q,     written_d;
    logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q,      wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,      rd_ptr_d;
    logic [OCC_W-1:0]      occ_q,         occ_d;
    logic                  in_ready_q,    in_ready_d;
    logic                  wrt_ena_q,     wrt_ena_d;
    logic [ADDR_WIDTH-1:0] write_addrs_q, write_addrs_d;
    logic [DATA_WIDTH-1:0] wrt_data_q,    wrt_data_d;
    logic                  busy_q,        busy_d;
    logic                  done_q,        done_d;
    logic                  error_q,       error_d;

    logic                  active_s;
    logic                  abort_s;
    logic                  push_s;
    logic                  pop_s;
    logic [ADDR_WIDTH:0]   range_sum_s;
    logic                  range_bad_s;

    // ABORT outranks both FIFO operations; the extra sum bit keeps the range check from wrapping.
    assign active_s    = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign abort_s     = active_s && ABORT;
    assign push_s      = (state_q == ST_LOAD) && !ABORT && IN_VALID && in_ready_q;
    assign pop_s       = active_s && !ABORT && (occ_q != OCC_ZERO) && !HOLD;
    assign range_sum_s = {1'b0, BASE_ADDRS} + {1'b0, LENGTH};
    assign range_bad_s = (range_sum_s > RANGE_LIMIT);

    // Next-state logic for the FSM, input FIFO, write port and status outputs.
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        length_d      = length_q;
        accepted_d    = accepted_q;
        written_d     = written_q;
        fifo_d        = fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        occ_d         = occ_q;
        wrt_ena_d     = 1'b0;
        write_addrs_d = write_addrs_q;
        wrt_data_d    = wrt_data_q;
        error_d       = 1'b0;

        if (abort_s) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            occ_d    = OCC_ZERO;
        end else begin
            if (push_s) begin
                fifo_d[wr_ptr_q] = IN_DATA;
                wr_ptr_d         = ptr_next(wr_ptr_q);
                accepted_d       = accepted_q + ADDR_WIDTH'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                wrt_ena_d     = 1'b1;
                wrt_data_d    = fifo_q[rd_ptr_q];
                write_addrs_d = base_q + written_q;
                written_d     = written_q + ADDR_WIDTH'(1);
                rd_ptr_d      = ptr_next(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s && !pop_s) begin
                occ_d = occ_q + OCC_W'(1);
            end else if (pop_s && !push_s) begin
                occ_d = occ_q - OCC_W'(1);
            end else begin
                occ_d = occ_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    base_d   = BASE_ADDRS;
                    length_d = LENGTH;
                    if (LENGTH == ADDR_ZERO) begin
                        state_d   = ST_FIN;
                        written_d = ADDR_ZERO;
                    end else if (range_bad_s) begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_LOAD;
                        written_d  = ADDR_ZERO;
                        accepted_d = ADDR_ZERO;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort_s) begin
                    state_d = ST_IDLE;
                end else if (accepted_d == length_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (abort_s) begin
                    state_d = ST_IDLE;
                end else if ((occ_q == OCC_ZERO) && (written_q == length_q)) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flops track the state being entered so they line up with it.
        in_ready_d = (state_d == ST_LOAD) && (occ_d < OCC_FULL) && (accepted_d < length_d);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_FIN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            base_q        <= ADDR_ZERO;
            length_q      <= ADDR_ZERO;
            accepted_q    <= ADDR_ZERO;
            written_q     <= ADDR_ZERO;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= DATA_ZERO;
            end
            wr_ptr_q      <= PTR_ZERO;
            rd_ptr_q      <= PTR_ZERO;
            occ_q         <= OCC_ZERO;
            in_ready_q    <= 1'b0;
            wrt_ena_q     <= 1'b0;
            write_addrs_q <= ADDR_ZERO;
            wrt_data_q    <= DATA_ZERO;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            length_q      <= length_d;
            accepted_q    <= accepted_d;
            written_q     <= written_d;
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            in_ready_q    <= in_ready_d;
            wrt_ena_q     <= wrt_ena_d;
            write_addrs_q <= write_addrs_d;
            wrt_data_q    <= wrt_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign IN_READY    = in_ready_q;
    assign WRT_ENA     = wrt_ena_q;
    assign WRITE_ADDRS = write_addrs_q;
    assign WRT_DATA    = wrt_data_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign ERROR       = error_q;
    assign COUNT       = written_q;

endmodule
